spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
SPI responder (slave) that forms the far end of the team's SPI master link; used for loopback in the sim wrapper and as a standalone peripheral.
- Oversamples SCLK/CS/MOSI in the GCLK domain, then shifts MOSI into a receive word and MISO out of a transmit word.
- Supports SPI modes 0-3 and 8/16/24/32-bit words, MSB first, matching the master's configuration encoding.
- Presents each received word with a one-cycle valid strobe.

Parameters:
SYNC_STAGES, 2, flip-flop stages on SCLK_in, CS_in and MOSI_in (legal values 2-3)

Ports:
GCLK  in  1  system clock; SCLK frequency must be ≤ GCLK/4
RST  in  1  synchronous, active-high reset
spi_mode_in  in  2  [1]=CPOL, [0]=CPHA; sampled at CS assertion
word_len_in  in  2  00=8, 01=16, 10=24, 11=32 bits; sampled at CS assertion and at each word boundary
tx_data_in  in  32  word to return on MISO, right-justified; sampled at CS assertion and at each word boundary
rx_data_out  out  32  last complete received word, right-justified, upper bits zero
rx_valid_out  out  1  one-GCLK pulse when rx_data_out updates
busy_out  out  1  high while synced CS is low
abort_out  out  1  one-GCLK pulse when CS deasserts mid-word
SCLK_in  in  1  asynchronous SPI clock
CS_in  in  1  asynchronous chip select, active low
MOSI_in  in  1  asynchronous data from master
MISO_out  out  1  data to master
MISO_oe_out  out  1  MISO output enable

Behaviour:
Reset values:
- All outputs 0; rx_data_out 0.
- FSM in IDLE; synchronizers preset to SCLK=0, CS=1, MOSI=0.
- RST mid-transfer abandons the word silently: no rx_valid_out, no abort_out.

Input conditioning:
- SCLK, CS and MOSI each pass through SYNC_STAGES flops plus one history flop.
- rise/fall = synced value XOR history.
- Leading edge: rising when CPOL=0, falling when CPOL=1. Trailing edge: the opposite.
- Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.

FSM states: IDLE, LOAD, SHIFT.
- IDLE:
  - MISO_oe_out=0, MISO_out=0, busy_out=0.
  - On synced CS falling, go to LOAD.
- LOAD (one cycle):
  - Latch mode and length.
  - tx_shift ← tx_data_in left-aligned to bit 31.
  - bit_cnt ← 0.
  - MISO_oe_out ← 1; busy_out ← 1.
  - If CPHA=0, MISO_out ← tx_shift MSB now. If CPHA=1, MISO_out holds 0 until the first shift edge.
  - Go to SHIFT.
- SHIFT:
  - On a sample edge: rx_shift ← {rx_shift[30:0], synced MOSI}; bit_cnt+1.
  - On a shift edge:
    - CPHA=1: drive the current MSB, and skip the first shift edge of each word so that bit is not advanced.
    - CPHA=0: advance to the next bit.
  - When bit_cnt reaches N on a sample edge, on the next GCLK:
    - rx_data_out ← rx_shift masked to N bits; rx_valid_out pulses.
    - tx_shift reloads from tx_data_in; bit_cnt ← 0; word_len_in re-sampled.
    - Stay in SHIFT, so back-to-back words work without CS toggle.
  - Synced CS rising:
    - bit_cnt=0: clean end, go to IDLE with no pulse.
    - bit_cnt≠0: pulse abort_out, go to IDLE, rx_data_out unchanged.
- Simultaneous CS rise and final sample edge in the same cycle: the word completes (rx_valid_out) and abort_out stays 0.
- SCLK edges while in IDLE or LOAD are ignored.
- Mode changes while busy take effect at the next CS assertion.
- Latency: rx_valid_out asserts SYNC_STAGES+2 GCLK after the pin-level final sample edge.

Decomposition:
- Package spi_pkg:
  - state enum {IDLE, LOAD, SHIFT}.
  - word_len_e encoding plus a function mapping it to bit count 8/16/24/32.
  - CPOL_BIT/CPHA_BIT index constants.
  - The master also uses this package.
- Sub-module spi_sync_edge: parameterised SYNC_STAGES synchronizer with rise/fall outputs and a reset value parameter; instantiated three times.

Test Plan:
- Mode 0, 8-bit, master sends 0xA5, tx_data_in=0x3C → master receives 0x3C; rx_data_out=0x000000A5; one rx_valid_out pulse.
- Mode 3, 32-bit, MOSI 0xDEADBEEF, tx 0x12345678 → rx_data_out=0xDEADBEEF; master reads 0x12345678.
- Mode 1, 16-bit, two words 0x1234 then 0xABCD in one CS window, tx_data_in changed to 0x5555 after the first pulse → two pulses; master reads 0x0000 then 0x5555.
- Mode 2, 24-bit, CS released after 10 bits → abort_out pulse, no rx_valid_out, MISO_oe_out=0, FSM IDLE.
- RST asserted mid-word in mode 0 → all outputs 0 next cycle; a following 8-bit transfer of 0x81 completes correctly.
- Each mode with SCLK=GCLK/4 → all words error-free.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, word-length encoding and mode bit indices.
// Used by both ends of the SPI link so the configuration encoding stays in step.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      WL_8  = 2'b00,
      WL_16 = 2'b01,
      WL_24 = 2'b10,
      WL_32 = 2'b11
   } word_len_e;

   localparam int CPOL_BIT = 1;
   localparam int CPHA_BIT = 0;

   // Number of bits in a word for a given length code.
   function automatic logic [5:0] word_bits(input word_len_e wl);
      case (wl)
         WL_8:    return 6'd8;
         WL_16:   return 6'd16;
         WL_24:   return 6'd24;
         default: return 6'd32;
      endcase
   endfunction

   // Mask keeping the low word_bits(wl) bits of a right-justified word.
   function automatic logic [31:0] word_mask(input word_len_e wl);
      return 32'hFFFF_FFFF >> (6'd32 - word_bits(wl));
   endfunction

   // Move a right-justified word up so its MSB sits at bit 31.
   function automatic logic [31:0] left_align(input logic [31:0] d, input word_len_e wl);
      return d << (6'd32 - word_bits(wl));
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus a history flop
// so the synced value can be compared with its previous cycle for edges.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d_in,
   output logic sync_out,
   output logic rise_out,
   output logic fall_out
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   hist_q, hist_d;

   // Next values: shift the pin into the chain, remember the last synced value.
   // NOTE: every _d is fully assigned in always_comb so no latch is inferred.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
      hist_d = sync_q[SYNC_STAGES-1];
   end

   // Synchronizer and history registers, preset to the pin's idle level.
   // NOTE: clocked state is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         hist_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         hist_q <= hist_d;
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];
   assign rise_out = sync_out & ~hist_q;
   assign fall_out = ~sync_out & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversamples SCLK/CS/MOSI in the GCLK domain, shifts MOSI into
// a receive word and MISO out of a transmit word, modes 0-3, 8/16/24/32 bits.
module spi_slave
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        GCLK,
   input  logic        RST,
   input  logic [1:0]  spi_mode_in,
   input  logic [1:0]  word_len_in,
   input  logic [31:0] tx_data_in,
   output logic [31:0] rx_data_out,
   output logic        rx_valid_out,
   output logic        busy_out,
   output logic        abort_out,
   input  logic        SCLK_in,
   input  logic        CS_in,
   input  logic        MOSI_in,
   output logic        MISO_out,
   output logic        MISO_oe_out
);

   logic sclk_sync, sclk_rise, sclk_fall;
   logic cs_sync, cs_rise, cs_fall;
   logic mosi_sync, mosi_rise, mosi_fall;

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(GCLK), .rst(RST), .d_in(SCLK_in),
      .sync_out(sclk_sync), .rise_out(sclk_rise), .fall_out(sclk_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(GCLK), .rst(RST), .d_in(CS_in),
      .sync_out(cs_sync), .rise_out(cs_rise), .fall_out(cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(GCLK), .rst(RST), .d_in(MOSI_in),
      .sync_out(mosi_sync), .rise_out(mosi_rise), .fall_out(mosi_fall)
   );

   // Only the SCLK/CS edges and the MOSI level are needed.
   logic unused_sync;
   assign unused_sync = &{1'b0, sclk_sync, cs_sync, mosi_rise, mosi_fall};

   state_e      state_q, state_d;
   logic [1:0]  mode_q, mode_d;
   word_len_e   len_q, len_d;
   logic [31:0] tx_shift_q, tx_shift_d;
   logic [31:0] rx_shift_q, rx_shift_d;
   logic [5:0]  bit_cnt_q, bit_cnt_d;
   logic        done_q, done_d;
   logic [31:0] rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        abort_q, abort_d;
   logic        busy_q, busy_d;
   logic        oe_q, oe_d;
   logic        miso_q, miso_d;

   logic        cpol, cpha;
   logic        lead_edge, trail_edge, sample_edge, shift_edge;
   word_len_e   len_in;
   logic [31:0] tx_aligned;

   assign cpol        = mode_q[CPOL_BIT];
   assign cpha        = mode_q[CPHA_BIT];
   assign lead_edge   = cpol ? sclk_fall : sclk_rise;
   assign trail_edge  = cpol ? sclk_rise : sclk_fall;
   assign sample_edge = cpha ? trail_edge : lead_edge;
   assign shift_edge  = cpha ? lead_edge  : trail_edge;
   assign len_in      = word_len_e'(word_len_in);
   assign tx_aligned  = left_align(tx_data_in, len_in);

   // Next-state logic: word framing, bit shifting, completion and abort.
   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      len_d      = len_q;
      tx_shift_d = tx_shift_q;
      rx_shift_d = rx_shift_q;
      bit_cnt_d  = bit_cnt_q;
      done_d     = 1'b0;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      abort_d    = 1'b0;
      busy_d     = busy_q;
      oe_d       = oe_q;
      miso_d     = miso_q;

      // A word finished on the previous cycle's sample edge: publish it,
      // even if CS rose on that same edge and the FSM is already idle.
      if (done_q) begin
         rx_data_d  = rx_shift_q & word_mask(len_q);
         rx_valid_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            oe_d   = 1'b0;
            miso_d = 1'b0;
            if (cs_fall) state_d = LOAD;
         end

         LOAD: begin
            mode_d     = spi_mode_in;
            len_d      = len_in;
            tx_shift_d = tx_aligned;
            bit_cnt_d  = 6'd0;
            oe_d       = 1'b1;
            busy_d     = 1'b1;
            miso_d     = spi_mode_in[CPHA_BIT] ? 1'b0 : tx_aligned[31];
            state_d    = SHIFT;
         end

         SHIFT: begin
            if (done_q) begin
               // Back-to-back word: reload without waiting for CS.
               len_d      = len_in;
               tx_shift_d = tx_aligned;
               bit_cnt_d  = 6'd0;
            end else if (sample_edge) begin
               rx_shift_d = {rx_shift_q[30:0], mosi_sync};
               bit_cnt_d  = bit_cnt_q + 6'd1;
               done_d     = (bit_cnt_d == word_bits(len_q));
            end else if (shift_edge) begin
               // The first shift edge of a word presents its MSB; later ones advance.
               if (bit_cnt_q == 6'd0) begin
                  miso_d = tx_shift_q[31];
               end else begin
                  tx_shift_d = {tx_shift_q[30:0], 1'b0};
                  miso_d     = tx_shift_q[30];
               end
            end

            if (cs_rise) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               oe_d    = 1'b0;
               miso_d  = 1'b0;
               abort_d = !done_d && (bit_cnt_d != 6'd0);
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset abandons any word in flight silently.
   always_ff @(posedge GCLK) begin
      if (RST) begin
         state_q    <= IDLE;
         mode_q     <= 2'b00;
         len_q      <= WL_8;
         tx_shift_q <= 32'd0;
         rx_shift_q <= 32'd0;
         bit_cnt_q  <= 6'd0;
         done_q     <= 1'b0;
         rx_data_q  <= 32'd0;
         rx_valid_q <= 1'b0;
         abort_q    <= 1'b0;
         busy_q     <= 1'b0;
         oe_q       <= 1'b0;
         miso_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         len_q      <= len_d;
         tx_shift_q <= tx_shift_d;
         rx_shift_q <= rx_shift_d;
         bit_cnt_q  <= bit_cnt_d;
         done_q     <= done_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         abort_q    <= abort_d;
         busy_q     <= busy_d;
         oe_q       <= oe_d;
         miso_q     <= miso_d;
      end
   end

   assign rx_data_out  = rx_data_q;
   assign rx_valid_out = rx_valid_q;
   assign busy_out     = busy_q;
   assign abort_out    = abort_q;
   assign MISO_out     = miso_q;
   assign MISO_oe_out  = oe_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a behavioural SPI master drives the pins,
// and expected words are computed from word length and data with plain arithmetic.
module tb_spi_slave;

   logic        GCLK = 1'b0;
   logic        RST  = 1'b1;
   logic [1:0]  spi_mode_in = 2'b00;
   logic [1:0]  word_len_in = 2'b00;
   logic [31:0] tx_data_in  = 32'd0;
   logic [31:0] rx_data_out;
   logic        rx_valid_out, busy_out, abort_out;
   logic        SCLK_in = 1'b0;
   logic        CS_in   = 1'b1;
   logic        MOSI_in = 1'b0;
   logic        MISO_out, MISO_oe_out;

   spi_slave #(.SYNC_STAGES(2)) dut (
      .GCLK(GCLK), .RST(RST),
      .spi_mode_in(spi_mode_in), .word_len_in(word_len_in), .tx_data_in(tx_data_in),
      .rx_data_out(rx_data_out), .rx_valid_out(rx_valid_out),
      .busy_out(busy_out), .abort_out(abort_out),
      .SCLK_in(SCLK_in), .CS_in(CS_in), .MOSI_in(MOSI_in),
      .MISO_out(MISO_out), .MISO_oe_out(MISO_oe_out)
   );

   always #5 GCLK = ~GCLK;

   int          checks = 0;
   int          errors = 0;
   int          h = 2;               // SCLK half period in GCLK cycles
   logic        cpol = 1'b0, cpha = 1'b0;
   logic [31:0] mosi_w [5];
   logic [31:0] tx_w   [5];
   logic [31:0] rx_q[$];
   int          abort_cnt = 0;
   logic [31:0] last_rx = 32'd0;

   // Record every valid strobe and abort pulse seen on the outputs.
   always @(negedge GCLK) begin
      if (rx_valid_out) rx_q.push_back(rx_data_out);
      if (abort_out) abort_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge GCLK);
   endtask

   // Master side of one word: sends nbits MSB-first from an n-bit word and
   // collects MISO just before the next shift edge. With simul set, CS rises
   // together with the last sample edge and the last MISO bit is not collected.
   task automatic shift_word(input int n, input logic [31:0] mo, input int nbits,
                             input bit simul, input logic [31:0] next_tx,
                             output logic [31:0] mi, output int got_bits);
      mi = 32'd0;
      got_bits = 0;
      for (int i = 0; i < nbits; i++) begin
         if (!cpha) begin
            MOSI_in = mo[n-1-i];
            wait_cyc(h);
            SCLK_in = ~cpol;
            if (simul && i == nbits - 1) begin
               CS_in = 1'b1;
            end else begin
               wait_cyc(h);
               mi = {mi[30:0], MISO_out};
               got_bits++;
               SCLK_in = cpol;
            end
         end else begin
            SCLK_in = ~cpol;
            MOSI_in = mo[n-1-i];
            wait_cyc(h);
            SCLK_in = cpol;
            if (simul && i == nbits - 1) begin
               CS_in = 1'b1;
            end else begin
               wait_cyc(h);
               mi = {mi[30:0], MISO_out};
               got_bits++;
            end
         end
         if (i == 0) tx_data_in = next_tx;
      end
   endtask

   // One CS window of nw words; the last word carries last_bits bits.
   task automatic xfer(input string name, input logic [1:0] mode, input logic [1:0] wl,
                       input int nw, input int last_bits, input bit simul);
      int          n, base, abase, exp_pulses, got_bits, nb;
      logic [31:0] mask, mi, exp_mi;
      n    = 8 * (int'(wl) + 1);
      mask = (n == 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
      cpol = mode[1];
      cpha = mode[0];
      SCLK_in     = cpol;
      spi_mode_in = mode;
      word_len_in = wl;
      tx_data_in  = tx_w[0];
      wait_cyc(6);
      base  = rx_q.size();
      abase = abort_cnt;
      CS_in = 1'b0;
      wait_cyc(8);
      check($sformatf("%s busy", name), busy_out, 32'd1);
      check($sformatf("%s oe", name), MISO_oe_out, 32'd1);
      for (int w = 0; w < nw; w++) begin
         nb = (w == nw - 1) ? last_bits : n;
         shift_word(n, mosi_w[w], nb, simul && (w == nw - 1), tx_w[w+1], mi, got_bits);
         exp_mi = (tx_w[w] & mask) >> (n - got_bits);
         check($sformatf("%s miso w%0d", name, w), mi, exp_mi);
      end
      CS_in = 1'b1;
      wait_cyc(10);
      SCLK_in = cpol;
      wait_cyc(4);
      exp_pulses = (last_bits == n) ? nw : nw - 1;
      check($sformatf("%s pulses", name), rx_q.size() - base, exp_pulses);
      for (int w = 0; w < exp_pulses; w++) begin
         if (base + w < rx_q.size())
            check($sformatf("%s rx w%0d", name, w), rx_q[base+w], mosi_w[w] & mask);
         last_rx = mosi_w[w] & mask;
      end
      check($sformatf("%s aborts", name), abort_cnt - abase, (last_bits == n) ? 0 : 1);
      check($sformatf("%s rx_data hold", name), rx_data_out, last_rx);
      check($sformatf("%s idle outs", name), {busy_out, MISO_oe_out, MISO_out}, 32'd0);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base, abase, gb, n, lb;
      logic [1:0]  m, wl;
      logic [31:0] mi;
      bit          sim;

      // Reset state
      wait_cyc(4);
      check("reset rx_data", rx_data_out, 32'd0);
      check("reset flags", {rx_valid_out, busy_out, abort_out, MISO_out, MISO_oe_out}, 32'd0);
      RST = 1'b0;
      wait_cyc(4);
      check("post-reset flags", {rx_valid_out, busy_out, abort_out, MISO_out, MISO_oe_out}, 32'd0);

      // Mode 0, 8-bit
      h = 2;
      mosi_w[0] = 32'hA5; tx_w[0] = 32'h3C; tx_w[1] = 32'h0;
      xfer("m0_8", 2'b00, 2'b00, 1, 8, 0);

      // Mode 3, 32-bit
      h = 3;
      mosi_w[0] = 32'hDEADBEEF; tx_w[0] = 32'h12345678; tx_w[1] = 32'h0;
      xfer("m3_32", 2'b11, 2'b11, 1, 32, 0);

      // Mode 1, 16-bit, two words in one CS window with tx changed between
      h = 2;
      mosi_w[0] = 32'h1234; mosi_w[1] = 32'hABCD;
      tx_w[0] = 32'h0000; tx_w[1] = 32'h5555; tx_w[2] = 32'h0;
      xfer("m1_16x2", 2'b01, 2'b01, 2, 16, 0);

      // Mode 2, 24-bit, CS released after 10 bits
      mosi_w[0] = 32'h00C3A5F0; tx_w[0] = 32'h00F0F0F0; tx_w[1] = 32'h0;
      xfer("m2_abort", 2'b10, 2'b10, 1, 10, 0);

      // CS rise coincident with the final sample edge
      mosi_w[0] = 32'h5E; tx_w[0] = 32'hB7;
      xfer("m0_simul", 2'b00, 2'b00, 1, 8, 1);
      mosi_w[0] = 32'h9C3E; tx_w[0] = 32'h4D21;
      xfer("m3_simul", 2'b11, 2'b01, 1, 16, 1);

      // Reset in the middle of a mode 0 word
      cpol = 1'b0; cpha = 1'b0; h = 2;
      SCLK_in = 1'b0; spi_mode_in = 2'b00; word_len_in = 2'b00; tx_data_in = 32'hFF;
      wait_cyc(6);
      base  = rx_q.size();
      abase = abort_cnt;
      CS_in = 1'b0;
      wait_cyc(8);
      shift_word(8, 32'h5A, 4, 0, 32'hFF, mi, gb);
      RST   = 1'b1;
      CS_in = 1'b1;
      wait_cyc(1);
      check("rst mid rx_data", rx_data_out, 32'd0);
      check("rst mid flags", {rx_valid_out, busy_out, abort_out, MISO_out, MISO_oe_out}, 32'd0);
      wait_cyc(1);
      RST = 1'b0;
      wait_cyc(10);
      check("rst mid pulses", rx_q.size() - base, 32'd0);
      check("rst mid aborts", abort_cnt - abase, 32'd0);
      last_rx = 32'd0;
      mosi_w[0] = 32'h81; tx_w[0] = 32'h7E;
      xfer("after_rst", 2'b00, 2'b00, 1, 8, 0);

      // Every mode at SCLK = GCLK/4, two back-to-back words
      for (int md = 0; md < 4; md++) begin
         h  = 2;
         wl = 2'($urandom_range(0, 3));
         for (int k = 0; k < 5; k++) begin
            mosi_w[k] = $urandom();
            tx_w[k]   = $urandom();
         end
         xfer($sformatf("fast_m%0d", md), 2'(md), wl, 2, 8 * (int'(wl) + 1), 0);
      end

      // Randomised transfers: mode, length, word count, speed, aborts, coincident CS
      for (int t = 0; t < 24; t++) begin
         m  = 2'($urandom_range(0, 3));
         wl = 2'($urandom_range(0, 3));
         h  = $urandom_range(2, 3);
         n  = 8 * (int'(wl) + 1);
         for (int k = 0; k < 5; k++) begin
            mosi_w[k] = $urandom();
            tx_w[k]   = $urandom();
         end
         lb  = n;
         sim = 1'b0;
         case ($urandom_range(0, 5))
            0: lb = $urandom_range(1, n - 1);
            1: sim = 1'b1;
            default: ;
         endcase
         xfer($sformatf("rnd%0d", t), m, wl, $urandom_range(1, 2), lb, sim);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
